// File: rtl/waypoint_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : waypoint_sequencer_pkg
// Description : Shared defaults, timer widths and the state encoding for the
//               waypoint sequencer and its millisecond interval timer.
// Contents    : DEF_* parameter defaults, TIMEOUT_W / DWELL_W, state_t enum.
// Revision    : 1.0 - initial release
// ============================================================================
package waypoint_sequencer_pkg;

    localparam int DEF_DEPTH       = 8;
    localparam int DEF_AW          = 3;
    localparam int DEF_CW          = 32;
    localparam int DEF_RESTART_CYC = 2;

    localparam int TIMEOUT_W = 32;
    localparam int DWELL_W   = 16;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD    = 3'd1,
        S_RESTART = 3'd2,
        S_RUN     = 3'd3,
        S_DWELL   = 3'd4,
        S_NEXT    = 3'd5,
        S_DONE    = 3'd6,
        S_FAULT   = 3'd7
    } state_t;

endpackage
`default_nettype wire

// File: rtl/waypoint_sequencer_ms_interval_timer.sv
`default_nettype none
// ============================================================================
// Module      : ms_interval_timer
// Description : Counts ms_tick pulses while clear is low and flags when the
//               count, including a tick arriving this cycle, equals limit.
// Ports       : clk, reset_n   - clock, async active-low reset
//               clear_i        - hold count at zero; ticks are ignored
//               ms_tick_i      - 1-cycle millisecond pulse
//               limit_i        - target count
//               hit_o          - combinational: count has reached limit
// Revision    : 1.0 - initial release
// ============================================================================
module ms_interval_timer
    import waypoint_sequencer_pkg::*;
#(
    parameter int W = TIMEOUT_W
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         clear_i,
    input  logic         ms_tick_i,
    input  logic [W-1:0] limit_i,
    output logic         hit_o
);

    logic [W-1:0] count_q;
    logic [W:0]   count_eff;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else if (clear_i) begin
            count_q <= '0;
        end else if (ms_tick_i) begin
            count_q <= count_q + 1'b1;
        end
    end

    // The tick of the current cycle is folded in so the owning FSM can act
    // in the same cycle the limit-th tick arrives (one bit wider: no wrap).
    always_comb begin
        count_eff = {1'b0, count_q} + {{W{1'b0}}, (ms_tick_i & ~clear_i)};
        hit_o     = (count_eff == {1'b0, limit_i});
    end

endmodule
`default_nettype wire

// File: rtl/waypoint_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : waypoint_sequencer
// Description : Steps a robot controller through up to DEPTH (x,y) waypoints:
//               load leg, pulse controller restart, run until reached (with
//               optional timeout), dwell, advance; optional looping.
// Ports       : clk, reset_n            - clock, async active-low reset
//               start_i, abort_i        - sequence control pulses
//               wp_wr_*_i               - waypoint memory write port
//               wp_count_i, loop_en_i   - sequence length / wrap enable
//               home_x_i, home_y_i      - initial position of first leg
//               dwell_ms_i, timeout_ms_i, ms_tick_i - timing controls
//               target_reached_i        - level from controller
//               target/initial_position_*_o, robot_controller_en_o,
//               ctrl_restart_o          - controller drive
//               wp_index_o, busy_o, done_o, fault_o, wr_reject_o - status
// Revision    : 1.0 - initial release
// ============================================================================
module waypoint_sequencer
    import waypoint_sequencer_pkg::*;
#(
    parameter int DEPTH       = DEF_DEPTH,
    parameter int AW          = DEF_AW,
    parameter int CW          = DEF_CW,
    parameter int RESTART_CYC = DEF_RESTART_CYC
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start_i,
    input  logic                 abort_i,
    input  logic                 wp_wr_en_i,
    input  logic [AW-1:0]        wp_wr_addr_i,
    input  logic [CW-1:0]        wp_wr_x_i,
    input  logic [CW-1:0]        wp_wr_y_i,
    input  logic [AW:0]          wp_count_i,
    input  logic                 loop_en_i,
    input  logic [CW-1:0]        home_x_i,
    input  logic [CW-1:0]        home_y_i,
    input  logic [DWELL_W-1:0]   dwell_ms_i,
    input  logic [TIMEOUT_W-1:0] timeout_ms_i,
    input  logic                 ms_tick_i,
    input  logic                 target_reached_i,
    output logic [CW-1:0]        target_position_x_o,
    output logic [CW-1:0]        target_position_y_o,
    output logic [CW-1:0]        initial_position_x_o,
    output logic [CW-1:0]        initial_position_y_o,
    output logic                 robot_controller_en_o,
    output logic                 ctrl_restart_o,
    output logic [AW-1:0]        wp_index_o,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 fault_o,
    output logic                 wr_reject_o
);

    localparam int              RCW          = (RESTART_CYC > 1) ? $clog2(RESTART_CYC) : 1;
    localparam logic [RCW-1:0]  RESTART_LAST = RCW'(RESTART_CYC - 1);
    localparam logic [AW:0]     DEPTH_CNT    = (AW+1)'(DEPTH);

    state_t          state_q;
    logic            first_q;      // high in the first cycle of every state
    logic [AW:0]     idx_q;
    logic [RCW-1:0]  rcnt_q;
    logic [CW-1:0]   prev_x_q, prev_y_q;
    logic [CW-1:0]   tgt_x_q, tgt_y_q, init_x_q, init_y_q;
    logic [AW-1:0]   wp_index_q;
    logic            en_q, restart_q, busy_q, done_q, fault_q, wr_reject_q;

    logic [CW-1:0]   mem_x_q [DEPTH];
    logic [CW-1:0]   mem_y_q [DEPTH];

    logic [AW:0]     count_eff;
    logic [AW:0]     idx_next;
    logic            leg_clear, dwell_clear, leg_hit, dwell_hit;

    assign count_eff   = (wp_count_i > DEPTH_CNT) ? DEPTH_CNT : wp_count_i;
    assign idx_next    = idx_q + 1'b1;
    // Clearing in the entry cycle keeps a tick coincident with entry uncounted.
    assign leg_clear   = (state_q != S_RUN)   | first_q;
    assign dwell_clear = (state_q != S_DWELL) | first_q;

    ms_interval_timer #(.W(TIMEOUT_W)) u_leg_timer (
        .clk       (clk),
        .reset_n   (reset_n),
        .clear_i   (leg_clear),
        .ms_tick_i (ms_tick_i),
        .limit_i   (timeout_ms_i),
        .hit_o     (leg_hit)
    );

    ms_interval_timer #(.W(DWELL_W)) u_dwell_timer (
        .clk       (clk),
        .reset_n   (reset_n),
        .clear_i   (dwell_clear),
        .ms_tick_i (ms_tick_i),
        .limit_i   (dwell_ms_i),
        .hit_o     (dwell_hit)
    );

    // Waypoint storage: deliberately not reset so contents survive reset_n.
    always_ff @(posedge clk) begin
        if (wp_wr_en_i && !busy_q) begin
            mem_x_q[wp_wr_addr_i] <= wp_wr_x_i;
            mem_y_q[wp_wr_addr_i] <= wp_wr_y_i;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_reject_q <= 1'b0;
        end else begin
            wr_reject_q <= wp_wr_en_i & busy_q;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            first_q    <= 1'b0;
            idx_q      <= '0;
            rcnt_q     <= '0;
            prev_x_q   <= '0;
            prev_y_q   <= '0;
            tgt_x_q    <= '0;
            tgt_y_q    <= '0;
            init_x_q   <= '0;
            init_y_q   <= '0;
            wp_index_q <= '0;
            en_q       <= 1'b0;
            restart_q  <= 1'b1;    // controller held in reset with us
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            fault_q    <= 1'b0;
        end else begin
            first_q <= 1'b0;
            if (abort_i) begin
                state_q   <= S_IDLE;
                first_q   <= 1'b1;
                en_q      <= 1'b0;
                restart_q <= 1'b0;
                busy_q    <= 1'b0;
                done_q    <= 1'b0;
                fault_q   <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE, S_DONE: begin
                        if (start_i && (count_eff != '0)) begin
                            idx_q     <= '0;
                            prev_x_q  <= home_x_i;
                            prev_y_q  <= home_y_i;
                            done_q    <= 1'b0;
                            busy_q    <= 1'b1;
                            restart_q <= 1'b0;   // restart high only in RESTART
                            state_q   <= S_LOAD;
                            first_q   <= 1'b1;
                        end
                    end
                    S_LOAD: begin
                        tgt_x_q    <= mem_x_q[idx_q[AW-1:0]];
                        tgt_y_q    <= mem_y_q[idx_q[AW-1:0]];
                        init_x_q   <= prev_x_q;
                        init_y_q   <= prev_y_q;
                        wp_index_q <= idx_q[AW-1:0];
                        restart_q  <= 1'b1;
                        en_q       <= 1'b0;
                        rcnt_q     <= '0;
                        state_q    <= S_RESTART;
                        first_q    <= 1'b1;
                    end
                    S_RESTART: begin
                        if (rcnt_q == RESTART_LAST) begin
                            restart_q <= 1'b0;
                            en_q      <= 1'b1;
                            state_q   <= S_RUN;
                            first_q   <= 1'b1;
                        end else begin
                            rcnt_q <= rcnt_q + 1'b1;
                        end
                    end
                    S_RUN: begin
                        // Reached is checked first so it wins a tie with timeout.
                        if (target_reached_i) begin
                            en_q    <= 1'b0;
                            state_q <= S_DWELL;
                            first_q <= 1'b1;
                        end else if ((timeout_ms_i != '0) && leg_hit) begin
                            en_q      <= 1'b0;
                            restart_q <= 1'b1;
                            fault_q   <= 1'b1;
                            busy_q    <= 1'b0;
                            state_q   <= S_FAULT;
                            first_q   <= 1'b1;
                        end
                    end
                    S_DWELL: begin
                        if (dwell_hit) begin
                            state_q <= S_NEXT;
                            first_q <= 1'b1;
                        end
                    end
                    S_NEXT: begin
                        prev_x_q <= tgt_x_q;
                        prev_y_q <= tgt_y_q;
                        first_q  <= 1'b1;
                        // ">=" also ends cleanly if wp_count shrank mid-run.
                        if (idx_next >= count_eff) begin
                            if (loop_en_i) begin
                                idx_q   <= '0;
                                state_q <= S_LOAD;
                            end else begin
                                done_q  <= 1'b1;
                                busy_q  <= 1'b0;
                                state_q <= S_DONE;
                            end
                        end else begin
                            idx_q   <= idx_next;
                            state_q <= S_LOAD;
                        end
                    end
                    S_FAULT: begin
                        // Held until abort.
                    end
                    default: begin
                        state_q <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign target_position_x_o   = tgt_x_q;
    assign target_position_y_o   = tgt_y_q;
    assign initial_position_x_o  = init_x_q;
    assign initial_position_y_o  = init_y_q;
    assign robot_controller_en_o = en_q;
    assign ctrl_restart_o        = restart_q;
    assign wp_index_o            = wp_index_q;
    assign busy_o                = busy_q;
    assign done_o                = done_q;
    assign fault_o               = fault_q;
    assign wr_reject_o           = wr_reject_q;

endmodule
`default_nettype wire

// File: tb/tb_waypoint_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_waypoint_sequencer
// Description : Self-checking bench for waypoint_sequencer. Legs, dwell exit
//               timing, timeout, loop, write rejection and reset are checked
//               against expectations computed from the sequencing rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_waypoint_sequencer;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0, abort = 1'b0, wp_wr_en = 1'b0;
    logic [2:0]  wp_wr_addr = '0;
    logic [31:0] wp_wr_x = '0, wp_wr_y = '0;
    logic [3:0]  wp_count = '0;
    logic        loop_en = 1'b0;
    logic [31:0] home_x = '0, home_y = '0;
    logic [15:0] dwell_ms = '0;
    logic [31:0] timeout_ms = '0;
    logic        ms_tick = 1'b0, target_reached = 1'b0;

    logic [31:0] tgt_x, tgt_y, ini_x, ini_y;
    logic        en, restart, busy, done, fault, wr_reject;
    logic [2:0]  wp_index;

    waypoint_sequencer dut (
        .clk                   (clk),
        .reset_n               (reset_n),
        .start_i               (start),
        .abort_i               (abort),
        .wp_wr_en_i            (wp_wr_en),
        .wp_wr_addr_i          (wp_wr_addr),
        .wp_wr_x_i             (wp_wr_x),
        .wp_wr_y_i             (wp_wr_y),
        .wp_count_i            (wp_count),
        .loop_en_i             (loop_en),
        .home_x_i              (home_x),
        .home_y_i              (home_y),
        .dwell_ms_i            (dwell_ms),
        .timeout_ms_i          (timeout_ms),
        .ms_tick_i             (ms_tick),
        .target_reached_i      (target_reached),
        .target_position_x_o   (tgt_x),
        .target_position_y_o   (tgt_y),
        .initial_position_x_o  (ini_x),
        .initial_position_y_o  (ini_y),
        .robot_controller_en_o (en),
        .ctrl_restart_o        (restart),
        .wp_index_o            (wp_index),
        .busy_o                (busy),
        .done_o                (done),
        .fault_o               (fault),
        .wr_reject_o           (wr_reject)
    );

    always #5 clk = ~clk;

    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          period = 3;
    logic [3:0]  rs_hist = '0;      // ctrl_restart of the last 4 samples, [0] newest
    logic [31:0] mx [8];
    logic [31:0] my [8];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one cycle; inputs for the new cycle are applied 1 time unit
    // after the edge, where outputs are sampled as well.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        start    = 1'b0;
        abort    = 1'b0;
        wp_wr_en = 1'b0;
        ms_tick  = ((cyc % period) == 0);
        rs_hist  = {rs_hist[2:0], restart};
    endtask

    task automatic wr_wp(input int a, input logic [31:0] x, input logic [31:0] y);
        wp_wr_en   = 1'b1;
        wp_wr_addr = a[2:0];
        wp_wr_x    = x;
        wp_wr_y    = y;
        mx[a]      = x;
        my[a]      = y;
        step();
    endtask

    task automatic wait_en(output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 100; k++) begin
            if (en === 1'b1) begin
                ok = 1'b1;
                break;
            end
            step();
        end
        if (!ok) chk("en_wait_expired", 64'd0, 64'd1);
    endtask

    // Cycle of the n-th ms_tick strictly after cycle c0.
    function automatic int nth_tick_after(input int c0, input int n);
        int c, k;
        c = c0;
        k = 0;
        while (k < n) begin
            c++;
            if ((c % period) == 0) k++;
        end
        return c;
    endfunction

    task automatic run_leg(input int idx, input logic [31:0] ix, input logic [31:0] iy,
                           input logic [31:0] tx, input logic [31:0] ty,
                           input int delay, input bit last, input bit inj_wr);
        bit ok;
        int d, t, exp_t, lows;
        wait_en(ok);
        if (!ok) return;
        chk("restart_window", {60'd0, rs_hist}, 64'b0110);
        chk("initial_x", ini_x, ix);
        chk("initial_y", ini_y, iy);
        chk("target_x", tgt_x, tx);
        chk("target_y", tgt_y, ty);
        chk("wp_index", wp_index, idx);
        chk("busy_run", busy, 1);
        if (inj_wr) begin
            wp_wr_en   = 1'b1;
            wp_wr_addr = 3'd2;
            wp_wr_x    = 32'hDEAD_BEEF;
            wp_wr_y    = 32'h0BAD_F00D;
        end
        lows = 0;
        for (int k = 0; k < delay; k++) begin
            step();
            if (en !== 1'b1) lows++;
            if (inj_wr && k == 0) chk("wr_reject_pulse", wr_reject, 1);
            if (inj_wr && k == 1) chk("wr_reject_once", wr_reject, 0);
        end
        chk("en_held_in_run", lows, 0);
        target_reached = 1'b1;
        step();
        target_reached = 1'b0;
        chk("en_off_dwell", en, 0);
        d = cyc;
        t = (dwell_ms == 16'd0) ? d : nth_tick_after(d, int'(dwell_ms));
        exp_t = last ? t + 2 : t + 3;
        ok = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            step();
            if ((last ? done : restart) === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        chk("dwell_exit_cycle", ok ? cyc : -1, exp_t);
        if (last) begin
            chk("done_en", en, 0);
            chk("done_busy", busy, 0);
            chk("done_hold_tx", tgt_x, tx);
        end
    endtask

    initial begin
        logic [31:0] px, py;
        int c5, cnt, eff;
        bit ok;

        // Reset values
        step();
        step();
        chk("rst_restart", restart, 1);
        chk("rst_en", en, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done_fault", {done, fault, wr_reject}, 0);
        chk("rst_target", {tgt_x, ini_y}, 0);
        reset_n = 1'b1;
        step();

        // Three-leg sequence; a write during leg 0 must be dropped
        wr_wp(0, 32'd10, 32'd0);
        wr_wp(1, 32'd10, 32'd20);
        wr_wp(2, -32'sd5, 32'd20);
        wp_count = 4'd3;
        dwell_ms = 16'd2;
        start = 1'b1;
        run_leg(0, 0, 0, 10, 0, 50, 0, 1);
        run_leg(1, 10, 0, 10, 20, 50, 0, 0);
        run_leg(2, 10, 20, -32'sd5, 20, 50, 1, 0);

        // Write while DONE is accepted; restart from DONE uses new home
        wr_wp(2, 32'd7, -32'sd3);
        chk("wr_idle_no_reject", wr_reject, 0);
        home_x = 32'd100;
        home_y = -32'sd100;
        dwell_ms = 16'd0;
        start = 1'b1;
        step();
        chk("start_clears_done", done, 0);
        chk("start_sets_busy", busy, 1);
        run_leg(0, 100, -32'sd100, 10, 0, 3, 0, 0);
        run_leg(1, 10, 0, 10, 20, 0, 0, 0);
        run_leg(2, 10, 20, 7, -32'sd3, 5, 1, 0);

        // Loop over two slots, then abort
        loop_en = 1'b1;
        wp_count = 4'd2;
        dwell_ms = 16'd1;
        start = 1'b1;
        run_leg(0, 100, -32'sd100, 10, 0, 4, 0, 0);
        run_leg(1, 10, 0, 10, 20, 4, 0, 0);
        run_leg(0, 10, 20, 10, 0, 4, 0, 0);
        chk("loop_busy", busy, 1);
        abort = 1'b1;
        step();
        chk("abort_busy", busy, 0);
        chk("abort_en", en, 0);
        chk("abort_restart", restart, 0);
        step();
        step();
        chk("abort_idle", {busy, en, done, fault}, 0);
        loop_en = 1'b0;

        // Timeout: fault on the 5th tick of RUN
        timeout_ms = 32'd5;
        period = 4;
        start = 1'b1;
        wait_en(ok);
        c5 = nth_tick_after(cyc, 5);
        while (cyc < c5) step();
        chk("pre_timeout_en", {en, fault}, 2'b10);
        step();
        chk("fault_set", fault, 1);
        chk("fault_en", en, 0);
        chk("fault_restart", restart, 1);
        chk("fault_busy", busy, 0);
        start = 1'b1;
        step();
        step();
        chk("fault_ignores_start", {fault, busy, restart}, 3'b101);
        abort = 1'b1;
        step();
        chk("abort_clears_fault", {fault, restart}, 0);

        // Reached coincident with the 5th tick: reached wins
        start = 1'b1;
        wait_en(ok);
        c5 = nth_tick_after(cyc, 5);
        while (cyc < c5) step();
        target_reached = 1'b1;
        step();
        target_reached = 1'b0;
        chk("tie_dwell_en", en, 0);
        chk("tie_no_fault", fault, 0);
        for (int k = 0; k < 10; k++) step();
        chk("tie_still_no_fault", fault, 0);
        abort = 1'b1;
        step();
        timeout_ms = 32'd0;

        // Start with zero waypoints is ignored
        wp_count = 4'd0;
        start = 1'b1;
        step();
        step();
        chk("count0_idle", {busy, restart, en}, 0);

        // Randomized sequences, incl. full depth and an over-range count
        for (int s = 0; s < 3; s++) begin
            period   = $urandom_range(2, 5);
            dwell_ms = 16'($urandom_range(0, 3));
            home_x   = $urandom;
            home_y   = $urandom;
            for (int a = 0; a < 8; a++) wr_wp(a, $urandom, $urandom);
            cnt = (s == 0) ? 8 : (s == 1) ? $urandom_range(9, 15) : $urandom_range(1, 7);
            eff = (cnt > 8) ? 8 : cnt;
            wp_count = 4'(cnt);
            start = 1'b1;
            px = home_x;
            py = home_y;
            for (int i = 0; i < eff; i++) begin
                run_leg(i, px, py, mx[i], my[i], $urandom_range(0, 15), (i == eff - 1), 0);
                px = mx[i];
                py = my[i];
            end
        end

        // Reset mid-RUN; memory survives
        wp_count = 4'd3;
        start = 1'b1;
        wait_en(ok);
        step();
        step();
        reset_n = 1'b0;
        #1;
        chk("midrst_restart", restart, 1);
        chk("midrst_en_busy", {en, busy, done, fault, wr_reject}, 0);
        chk("midrst_pos", {tgt_x, tgt_y}, 0);
        chk("midrst_ini_idx", {ini_x, wp_index}, 0);
        step();
        reset_n = 1'b1;
        step();
        step();
        chk("postrst_idle", {busy, en, restart}, 3'b001);
        wp_count = 4'd1;
        start = 1'b1;
        run_leg(0, home_x, home_y, mx[0], my[0], 2, 1, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
